// File: rtl/axi4l_if.sv
// AXI4-Lite link between one master and one slave.
// The master drives aclk/aresetn from its own clock and reset.
interface axi4l_if;
  logic        aclk;
  logic        aresetn;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output aclk, aresetn,
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input aclk, aresetn,
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface

// File: rtl/axi4l_master_bridge.sv
// Bridges the core's req/gnt/rvalid data port onto an AXI4-Lite master link.
// One transaction in flight at a time; all AXI-side signals come from flops.
module axi4l_master_bridge #(
  parameter logic [2:0] AXI_PROT = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  axi4l_if.master     axi
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RRESP} state_t;

  state_t      state;
  logic        aw_valid;
  logic        w_valid;
  logic        ar_valid;
  logic        b_ready;
  logic        r_ready;
  logic [31:0] aw_addr;
  logic [31:0] ar_addr;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        aw_done;
  logic        w_done;

  assign axi.aclk    = clk;
  assign axi.aresetn = rst_n;
  assign axi.awvalid = aw_valid;
  assign axi.awaddr  = aw_addr;
  assign axi.awprot  = AXI_PROT;
  assign axi.wvalid  = w_valid;
  assign axi.wdata   = w_data;
  assign axi.wstrb   = w_strb;
  assign axi.bready  = b_ready;
  assign axi.arvalid = ar_valid;
  assign axi.araddr  = ar_addr;
  assign axi.arprot  = AXI_PROT;
  assign axi.rready  = r_ready;

  // Gating with rst_n keeps the grant low while reset is held.
  assign data_gnt_o = data_req_i && (state == IDLE) && rst_n;

  // A channel is done once its valid has dropped or is being accepted now.
  assign aw_done = !aw_valid || axi.awready;
  assign w_done  = !w_valid  || axi.wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_valid      <= 1'b0;
      w_valid       <= 1'b0;
      ar_valid      <= 1'b0;
      b_ready       <= 1'b0;
      r_ready       <= 1'b0;
      aw_addr       <= '0;
      ar_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (data_gnt_o) begin
            w_data <= data_wdata_i;
            w_strb <= data_be_i;
            if (data_we_i) begin
              aw_addr  <= {data_addr_i[31:2], 2'b00};
              aw_valid <= 1'b1;
              w_valid  <= 1'b1;
              state    <= WRITE;
            end else begin
              ar_addr  <= {data_addr_i[31:2], 2'b00};
              ar_valid <= 1'b1;
              state    <= RADDR;
            end
          end
        end
        WRITE: begin
          if (axi.awready) aw_valid <= 1'b0;
          if (axi.wready)  w_valid  <= 1'b0;
          if (aw_done && w_done) begin
            b_ready <= 1'b1;
            state   <= WRESP;
          end
        end
        WRESP: begin
          if (axi.bvalid) begin
            b_ready       <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_err_o    <= (axi.bresp != 2'b00);
            state         <= IDLE;
          end
        end
        RADDR: begin
          if (axi.arready) begin
            ar_valid <= 1'b0;
            r_ready  <= 1'b1;
            state    <= RRESP;
          end
        end
        RRESP: begin
          if (axi.rvalid) begin
            r_ready       <= 1'b0;
            data_rdata_o  <= axi.rdata;
            data_rvalid_o <= 1'b1;
            data_err_o    <= (axi.rresp != 2'b00);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4l_master_bridge.md
Name: axi4l_master_bridge

Overview:
- Converts the Ibex-style data bus (req/gnt/rvalid) into AXI4-Lite master transactions on an axi4l_if.
- It is the initiator end of the link that axi4l slaves (timer, UART, RAM) respond to. It sits between the core LSU port and the SoC AXI4-Lite interconnect.
- Exactly one transaction is outstanding at a time. Every AXI output is registered.

Parameters:
- AXI_PROT, 3'b000, constant value driven on awprot and arprot.

Ports:
- clk  input  1  system clock; axi.aclk is driven from it.
- rst_n  input  1  asynchronous active-low reset; axi.aresetn follows it.
- data_req_i  input  1  request valid from the core.
- data_gnt_o  output  1  request accepted this cycle.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  4  byte enables.
- data_addr_i  input  32  byte address.
- data_wdata_i  input  32  write data.
- data_rvalid_o  output  1  one-cycle response pulse.
- data_rdata_o  output  32  read data, valid with data_rvalid_o.
- data_err_o  output  1  error response, valid with data_rvalid_o.
- axi  interface  -  axi4l_if master modport:
  - driven: awvalid/awaddr/awprot, wvalid/wdata/wstrb, bready, arvalid/araddr/arprot, rready.
  - sampled: awready, wready, bvalid/bresp, arready, rvalid/rdata/rresp.

Behaviour:
- Reset (async, rst_n low) forces the following, immediately and independent of clk:
  - state = IDLE.
  - awvalid, wvalid, arvalid, bready, rready = 0.
  - data_gnt_o = 0, data_rvalid_o = 0, data_err_o = 0.
  - data_rdata_o = 0, awaddr/araddr = 0, wdata = 0, wstrb = 0.
- FSM states: IDLE, WRITE, WRESP, RADDR, RRESP.
- Grant: data_gnt_o = data_req_i && state == IDLE. It is combinational and is the only combinational output.
- On a grant, the bridge captures:
  - address with bits [1:0] forced to 0,
  - data_be_i into wstrb,
  - data_wdata_i into wdata.
- IDLE -> WRITE (granted write):
  - awvalid = 1 and wvalid = 1 on the next cycle.
- WRITE:
  - awvalid drops the cycle after awvalid && awready; wvalid drops the cycle after wvalid && wready, independently.
  - Go to WRESP once both handshakes have completed. They may complete in the same cycle or in either order.
  - The minimum WRITE dwell is 1 cycle.
- WRESP:
  - bready = 1 for the whole state.
  - On bvalid: go to IDLE, bready = 0, data_rvalid_o = 1 for exactly one cycle.
  - data_err_o = (bresp != OKAY); SLVERR and DECERR both count as errors.
- IDLE -> RADDR (granted read):
  - arvalid = 1 on the next cycle, dropped after the arready handshake, then go to RRESP.
- RRESP:
  - rready = 1.
  - On rvalid: capture rdata into data_rdata_o, data_err_o = (rresp != OKAY), data_rvalid_o = 1 for one cycle, go to IDLE.
  - data_rdata_o holds its value until the next read response.
  - On a write response, data_rdata_o is unchanged.
- Back-to-back: a grant may occur in the same cycle data_rvalid_o is high. Minimum request-to-request spacing: write 3 cycles, read 3 cycles.
- AXI rules:
  - No valid depends combinationally on any ready.
  - Payload (addr, prot, data, strb) is stable while valid && !ready.
  - No valid rises in the first cycle after reset deassertion.
- wstrb = 4'b0000 is forwarded unchanged; the bridge does not filter or special-case it.
- Mid-transaction reset: all outputs return to reset values asynchronously. No response is generated for the aborted request.
- A response received while not in the matching response state (bvalid outside WRESP, rvalid outside RRESP) is ignored, because bready/rready are 0.

Test Plan:
- Write, addr 0x0000_0004, wdata 0x1234_5678, be 4'hF; slave asserts awready and wready together:
  - awaddr = 0x4, wdata = 0x12345678, wstrb = F.
  - bresp OKAY -> one data_rvalid_o pulse, data_err_o = 0.
- Write with awready 3 cycles before wready:
  - awvalid drops first; wvalid/wdata/wstrb stay stable until wready.
  - Exactly one response pulse.
- Read, addr 0x0000_0003; slave holds arready low for 4 cycles:
  - araddr = 0x0 and stable throughout.
  - rdata 0xDEAD_BEEF -> data_rdata_o = 0xDEADBEEF, data_err_o = 0.
- Read returning SLVERR, then a write returning DECERR:
  - Both give data_err_o = 1 with data_rvalid_o.
  - data_rdata_o is unchanged by the write.
- rst_n asserted in WRITE with awvalid = 1:
  - awvalid/wvalid fall immediately, state = IDLE, no data_rvalid_o.
  - After release, the next request is granted normally.
- Formal: an axi4l slave-side property checker bound to the interface proves valid/payload stability and reset-low valids. Required covers:
  - 5 consecutive writes,
  - 5 consecutive reads,
  - mixed read/write traffic.
